// File: rtl/breport_parse.sv
// Beacon-report parser: forwards ordinary packets with a fixed 3-cycle latency,
// extracts beacon reports into rpt_* outputs. Define BREPORT_FWD_EN to also forward beacons.
module breport_parse #(
    parameter logic [47:0] CNC_MAC   = 48'h010203040506,
    parameter int          RPT_WORDS = 13
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_data_wr,
    input  logic [133:0] in_data,
    input  logic         in_data_valid,
    input  logic         in_data_valid_wr,
    output logic         out_data_wr,
    output logic [133:0] out_data,
    output logic         out_data_valid,
    output logic         out_data_valid_wr,
    output logic         rpt_valid,
    output logic [47:0]  rpt_src_mac,
    output logic [47:0]  rpt_timestamp,
    output logic [47:0]  rpt_direct_mac,
    output logic         rpt_direction,
    output logic [31:0]  rpt_token_bucket,
    output logic [127:0] rpt_esw_cnt,
    output logic [7:0]   rpt_node_id,
    output logic [7:0]   rpt_bufm_id_cnt,
    output logic [127:0] rpt_eos_md_cnt,
    output logic [23:0]  rpt_eos_q_used,
    output logic [255:0] rpt_goe_cnt,
    output logic [31:0]  rpt_cnt,
    output logic [15:0]  err_cnt
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLASS   = 3'd1,
        BEACON  = 3'd2,
        PASS    = 3'd3,
        DISCARD = 3'd4
    } state_t;

    localparam logic [1:0] TAG_FIRST = 2'b01;
    localparam logic [1:0] TAG_LAST  = 2'b10;
    localparam logic [3:0] LAST_IDX  = 4'(RPT_WORDS - 1);

    state_t state_q, state_d;
    logic [3:0] idx_q, idx_d, cur_idx;
    logic [1:0] tag;
    logic hdr_match, err_inc, accept, bcn_word, kill_flag, clr_flag, drop, kill;

    // Shadow registers filled while a beacon is being received
    logic [47:0]  src_mac_q, src_mac_d, ts_q, ts_d, dmac_q, dmac_d;
    logic         dir_q, dir_d;
    logic [31:0]  tb_q, tb_d;
    logic [127:0] esw_q, esw_d, eos_md_q, eos_md_d, goe_hi_q, goe_hi_d;
    logic [7:0]   node_q, node_d, bufm_q, bufm_d;
    logic [23:0]  eos_q_q, eos_q_d;

    logic         rpt_valid_q, rpt_valid_d, rpt_dir_q, rpt_dir_d;
    logic [47:0]  rpt_src_q, rpt_src_d, rpt_ts_q, rpt_ts_d, rpt_dmac_q, rpt_dmac_d;
    logic [31:0]  rpt_tb_q, rpt_tb_d, rpt_cnt_q, rpt_cnt_d;
    logic [127:0] rpt_esw_q, rpt_esw_d, rpt_eos_md_q, rpt_eos_md_d;
    logic [7:0]   rpt_node_q, rpt_node_d, rpt_bufm_q, rpt_bufm_d;
    logic [23:0]  rpt_eos_q_q, rpt_eos_q_d;
    logic [255:0] rpt_goe_q, rpt_goe_d;
    logic [15:0]  err_cnt_q, err_cnt_d;

    // Three-stage delay line; the flag marks words of a packet not yet classified
    logic         s1_wr_q, s1_wr_d, s2_wr_q, s2_wr_d, s3_wr_q, s3_wr_d;
    logic         s1_vwr_q, s1_vwr_d, s2_vwr_q, s2_vwr_d, s3_vwr_q, s3_vwr_d;
    logic         s1_val_q, s1_val_d, s2_val_q, s2_val_d, s3_val_q, s3_val_d;
    logic         s1_flag_q, s1_flag_d, s2_flag_q, s2_flag_d;
    logic [133:0] s1_data_q, s1_data_d, s2_data_q, s2_data_d, s3_data_q, s3_data_d;
    logic         drop_last_q, drop_last_d;

    // Packet FSM, word index and shadow capture
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        err_inc   = 1'b0;
        accept    = 1'b0;
        bcn_word  = 1'b0;
        kill_flag = 1'b0;
        clr_flag  = 1'b0;
        src_mac_d = src_mac_q;
        ts_d      = ts_q;
        dmac_d    = dmac_q;
        dir_d     = dir_q;
        tb_d      = tb_q;
        esw_d     = esw_q;
        node_d    = node_q;
        bufm_d    = bufm_q;
        eos_md_d  = eos_md_q;
        eos_q_d   = eos_q_q;
        goe_hi_d  = goe_hi_q;
        tag       = in_data[133:132];
        cur_idx   = (tag == TAG_FIRST) ? 4'd0 : idx_q;
        hdr_match = (in_data[127:80] == CNC_MAC) && (in_data[31:16] == 16'h88F7)
                    && (in_data[11:8] == 4'hE);
        if (in_data_wr) begin
            idx_d = cur_idx + 4'd1;
            if (tag == TAG_FIRST) begin
                // A first-word tag always restarts classification, aborting any packet in flight
                err_inc  = (state_q == BEACON);
                clr_flag = 1'b1;
                state_d  = CLASS;
            end else begin
                case (state_q)
                    CLASS: begin
                        if (cur_idx == 4'd2) begin
                            clr_flag = 1'b1;
                            if (hdr_match) begin
                                bcn_word  = 1'b1;
                                kill_flag = 1'b1;
                                src_mac_d = in_data[79:32];
                                if (tag == TAG_LAST) begin
                                    err_inc = 1'b1;
                                    state_d = IDLE;
                                end else begin
                                    state_d = BEACON;
                                end
                            end else begin
                                state_d = (tag == TAG_LAST) ? IDLE : PASS;
                            end
                        end else if (tag == TAG_LAST) begin
                            clr_flag = 1'b1;
                            state_d  = IDLE;
                        end else begin
                            state_d = CLASS;
                        end
                    end
                    BEACON: begin
                        bcn_word = 1'b1;
                        case (cur_idx)
                            4'd5:  ts_d = in_data[95:48];
                            4'd6: begin
                                dmac_d = in_data[127:80];
                                dir_d  = in_data[79];
                                tb_d   = in_data[63:32];
                            end
                            4'd7:  esw_d = in_data[127:0];
                            4'd8: begin
                                node_d = in_data[127:120];
                                bufm_d = in_data[119:112];
                            end
                            4'd9:  eos_md_d = in_data[127:0];
                            4'd10: eos_q_d  = in_data[127:104];
                            4'd11: goe_hi_d = in_data[127:0];
                            default: ;
                        endcase
                        if (cur_idx == LAST_IDX) begin
                            if (tag == TAG_LAST) begin
                                accept  = 1'b1;
                                state_d = IDLE;
                            end else begin
                                err_inc = 1'b1;
                                state_d = DISCARD;
                            end
                        end else if (tag == TAG_LAST) begin
                            err_inc = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = BEACON;
                        end
                    end
                    DISCARD: begin
                        bcn_word = 1'b1;
                        state_d  = (tag == TAG_LAST) ? IDLE : DISCARD;
                    end
                    PASS: state_d = (tag == TAG_LAST) ? IDLE : PASS;
                    default: state_d = IDLE;
                endcase
            end
        end else begin
            idx_d = idx_q;
        end
    end

    // Report publication and counters; the last GOE half comes straight from the closing word
    always_comb begin
        rpt_valid_d = accept;
        rpt_cnt_d   = accept ? (rpt_cnt_q + 32'd1) : rpt_cnt_q;
        err_cnt_d   = (err_inc && (err_cnt_q != 16'hFFFF)) ? (err_cnt_q + 16'd1) : err_cnt_q;
        if (accept) begin
            rpt_src_d    = src_mac_q;
            rpt_ts_d     = ts_q;
            rpt_dmac_d   = dmac_q;
            rpt_dir_d    = dir_q;
            rpt_tb_d     = tb_q;
            rpt_esw_d    = esw_q;
            rpt_node_d   = node_q;
            rpt_bufm_d   = bufm_q;
            rpt_eos_md_d = eos_md_q;
            rpt_eos_q_d  = eos_q_q;
            rpt_goe_d    = {goe_hi_q, in_data[127:0]};
        end else begin
            rpt_src_d    = rpt_src_q;
            rpt_ts_d     = rpt_ts_q;
            rpt_dmac_d   = rpt_dmac_q;
            rpt_dir_d    = rpt_dir_q;
            rpt_tb_d     = rpt_tb_q;
            rpt_esw_d    = rpt_esw_q;
            rpt_node_d   = rpt_node_q;
            rpt_bufm_d   = rpt_bufm_q;
            rpt_eos_md_d = rpt_eos_md_q;
            rpt_eos_q_d  = rpt_eos_q_q;
            rpt_goe_d    = rpt_goe_q;
        end
    end

    // Delay line; a beacon verdict at index 2 retracts the two earlier words still in flight
    always_comb begin
`ifdef BREPORT_FWD_EN
        drop = 1'b0;
        kill = 1'b0;
`else
        drop = bcn_word;
        kill = kill_flag;
`endif
        drop_last_d = in_data_wr ? drop : drop_last_q;
        s1_wr_d     = in_data_wr & ~drop;
        s1_vwr_d    = in_data_valid_wr & ~drop_last_d;
        s1_val_d    = in_data_valid;
        s1_data_d   = in_data;
        s1_flag_d   = in_data_wr & (state_d == CLASS);
        s2_wr_d     = s1_wr_q & ~(kill & s1_flag_q);
        s2_vwr_d    = s1_vwr_q & ~(kill & s1_flag_q);
        s2_val_d    = s1_val_q;
        s2_data_d   = s1_data_q;
        s2_flag_d   = s1_flag_q & ~clr_flag;
        s3_wr_d     = s2_wr_q & ~(kill & s2_flag_q);
        s3_vwr_d    = s2_vwr_q & ~(kill & s2_flag_q);
        s3_val_d    = s2_val_q;
        s3_data_d   = s2_data_q;
    end

    // State, shadow, report and pipeline registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= 4'd0;
            src_mac_q    <= 48'd0;
            ts_q         <= 48'd0;
            dmac_q       <= 48'd0;
            dir_q        <= 1'b0;
            tb_q         <= 32'd0;
            esw_q        <= 128'd0;
            node_q       <= 8'd0;
            bufm_q       <= 8'd0;
            eos_md_q     <= 128'd0;
            eos_q_q      <= 24'd0;
            goe_hi_q     <= 128'd0;
            rpt_valid_q  <= 1'b0;
            rpt_src_q    <= 48'd0;
            rpt_ts_q     <= 48'd0;
            rpt_dmac_q   <= 48'd0;
            rpt_dir_q    <= 1'b0;
            rpt_tb_q     <= 32'd0;
            rpt_esw_q    <= 128'd0;
            rpt_node_q   <= 8'd0;
            rpt_bufm_q   <= 8'd0;
            rpt_eos_md_q <= 128'd0;
            rpt_eos_q_q  <= 24'd0;
            rpt_goe_q    <= 256'd0;
            rpt_cnt_q    <= 32'd0;
            err_cnt_q    <= 16'd0;
            s1_wr_q      <= 1'b0;
            s2_wr_q      <= 1'b0;
            s3_wr_q      <= 1'b0;
            s1_vwr_q     <= 1'b0;
            s2_vwr_q     <= 1'b0;
            s3_vwr_q     <= 1'b0;
            s1_val_q     <= 1'b0;
            s2_val_q     <= 1'b0;
            s3_val_q     <= 1'b0;
            s1_flag_q    <= 1'b0;
            s2_flag_q    <= 1'b0;
            s1_data_q    <= 134'd0;
            s2_data_q    <= 134'd0;
            s3_data_q    <= 134'd0;
            drop_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            src_mac_q    <= src_mac_d;
            ts_q         <= ts_d;
            dmac_q       <= dmac_d;
            dir_q        <= dir_d;
            tb_q         <= tb_d;
            esw_q        <= esw_d;
            node_q       <= node_d;
            bufm_q       <= bufm_d;
            eos_md_q     <= eos_md_d;
            eos_q_q      <= eos_q_d;
            goe_hi_q     <= goe_hi_d;
            rpt_valid_q  <= rpt_valid_d;
            rpt_src_q    <= rpt_src_d;
            rpt_ts_q     <= rpt_ts_d;
            rpt_dmac_q   <= rpt_dmac_d;
            rpt_dir_q    <= rpt_dir_d;
            rpt_tb_q     <= rpt_tb_d;
            rpt_esw_q    <= rpt_esw_d;
            rpt_node_q   <= rpt_node_d;
            rpt_bufm_q   <= rpt_bufm_d;
            rpt_eos_md_q <= rpt_eos_md_d;
            rpt_eos_q_q  <= rpt_eos_q_d;
            rpt_goe_q    <= rpt_goe_d;
            rpt_cnt_q    <= rpt_cnt_d;
            err_cnt_q    <= err_cnt_d;
            s1_wr_q      <= s1_wr_d;
            s2_wr_q      <= s2_wr_d;
            s3_wr_q      <= s3_wr_d;
            s1_vwr_q     <= s1_vwr_d;
            s2_vwr_q     <= s2_vwr_d;
            s3_vwr_q     <= s3_vwr_d;
            s1_val_q     <= s1_val_d;
            s2_val_q     <= s2_val_d;
            s3_val_q     <= s3_val_d;
            s1_flag_q    <= s1_flag_d;
            s2_flag_q    <= s2_flag_d;
            s1_data_q    <= s1_data_d;
            s2_data_q    <= s2_data_d;
            s3_data_q    <= s3_data_d;
            drop_last_q  <= drop_last_d;
        end
    end

    assign out_data_wr       = s3_wr_q;
    assign out_data          = s3_data_q;
    assign out_data_valid    = s3_val_q;
    assign out_data_valid_wr = s3_vwr_q;
    assign rpt_valid         = rpt_valid_q;
    assign rpt_src_mac       = rpt_src_q;
    assign rpt_timestamp     = rpt_ts_q;
    assign rpt_direct_mac    = rpt_dmac_q;
    assign rpt_direction     = rpt_dir_q;
    assign rpt_token_bucket  = rpt_tb_q;
    assign rpt_esw_cnt       = rpt_esw_q;
    assign rpt_node_id       = rpt_node_q;
    assign rpt_bufm_id_cnt   = rpt_bufm_q;
    assign rpt_eos_md_cnt    = rpt_eos_md_q;
    assign rpt_eos_q_used    = rpt_eos_q_q;
    assign rpt_goe_cnt       = rpt_goe_q;
    assign rpt_cnt           = rpt_cnt_q;
    assign err_cnt           = err_cnt_q;

endmodule

// File: tb/tb_breport_parse.sv
// Bench for breport_parse: directed scenarios followed by random packets checked
// against a packet-level reference model.
`timescale 1ns/1ps
module tb_breport_parse;

    localparam logic [47:0] MAC  = 48'h010203040506;
    localparam int          MAXC = 4096;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_data_wr, in_data_valid, in_data_valid_wr;
    logic [133:0] in_data;
    logic         out_data_wr, out_data_valid, out_data_valid_wr, rpt_valid, rpt_direction;
    logic [133:0] out_data;
    logic [47:0]  rpt_src_mac, rpt_timestamp, rpt_direct_mac;
    logic [31:0]  rpt_token_bucket, rpt_cnt;
    logic [127:0] rpt_esw_cnt, rpt_eos_md_cnt;
    logic [7:0]   rpt_node_id, rpt_bufm_id_cnt;
    logic [23:0]  rpt_eos_q_used;
    logic [255:0] rpt_goe_cnt;
    logic [15:0]  err_cnt;

    always #5 clk = ~clk;

    breport_parse #(.CNC_MAC(MAC), .RPT_WORDS(13)) dut (
        .clk(clk), .rst(rst),
        .in_data_wr(in_data_wr), .in_data(in_data),
        .in_data_valid(in_data_valid), .in_data_valid_wr(in_data_valid_wr),
        .out_data_wr(out_data_wr), .out_data(out_data),
        .out_data_valid(out_data_valid), .out_data_valid_wr(out_data_valid_wr),
        .rpt_valid(rpt_valid), .rpt_src_mac(rpt_src_mac), .rpt_timestamp(rpt_timestamp),
        .rpt_direct_mac(rpt_direct_mac), .rpt_direction(rpt_direction),
        .rpt_token_bucket(rpt_token_bucket), .rpt_esw_cnt(rpt_esw_cnt),
        .rpt_node_id(rpt_node_id), .rpt_bufm_id_cnt(rpt_bufm_id_cnt),
        .rpt_eos_md_cnt(rpt_eos_md_cnt), .rpt_eos_q_used(rpt_eos_q_used),
        .rpt_goe_cnt(rpt_goe_cnt), .rpt_cnt(rpt_cnt), .err_cnt(err_cnt)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit fwd;

    logic         exp_wr  [MAXC];
    logic [133:0] exp_data[MAXC];
    logic         exp_vwr [MAXC];
    logic         exp_rv  [MAXC];

    logic [133:0] pkt [32];
    int           plen;

    logic [47:0]  m_src, m_ts, m_dmac;
    logic         m_dir;
    logic [31:0]  m_tb, m_rpt_cnt;
    logic [127:0] m_esw, m_eos_md;
    logic [7:0]   m_node, m_bufm;
    logic [23:0]  m_eos_q;
    logic [255:0] m_goe;
    logic [15:0]  m_err;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        m_src = '0; m_ts = '0; m_dmac = '0; m_dir = 1'b0; m_tb = '0; m_rpt_cnt = '0;
        m_esw = '0; m_eos_md = '0; m_node = '0; m_bufm = '0; m_eos_q = '0; m_goe = '0;
        m_err = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (cyc >= MAXC - 8) begin
            fails++;
            $display("FAIL cycle_budget: observed %0d cycles, expected below %0d", cyc, MAXC - 8);
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $fatal(1, "cycle budget exhausted");
        end
        chk("out_data_wr", out_data_wr, exp_wr[cyc]);
        chk("out_data_valid_wr", out_data_valid_wr, exp_vwr[cyc]);
        if (exp_wr[cyc]) chk("out_data", out_data, exp_data[cyc]);
        if (exp_vwr[cyc]) chk("out_data_valid", out_data_valid, 1'b1);
        chk("rpt_valid", rpt_valid, exp_rv[cyc]);
    endtask

    task automatic idle_step();
        in_data_wr = 1'b0; in_data_valid = 1'b0; in_data_valid_wr = 1'b0;
        step();
    endtask

    function automatic bit hdr_ok(input logic [133:0] w);
        return (w[127:80] == MAC) && (w[31:16] == 16'h88F7) && (w[11:8] == 4'hE);
    endfunction

    task automatic mk_pkt(input int n, input bit bcn, input bit term);
        logic [159:0] r;
        plen = n;
        for (int i = 0; i < n; i++) begin
            r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            pkt[i] = r[133:0];
            if (i == 0) pkt[i][133:132] = 2'b01;
            else if (term && i == n - 1) pkt[i][133:132] = 2'b10;
            else pkt[i][133:132] = 2'b11;
            if (i == 2) begin
                if (bcn) begin
                    pkt[i][127:80] = MAC;
                    pkt[i][31:16]  = 16'h88F7;
                    pkt[i][11:8]   = 4'hE;
                end else begin
                    pkt[i][31:16] = 16'h0800;
                end
            end
        end
    endtask

    // Drive the staged packet; the model decides its fate from the whole packet up front
    task automatic send_pkt(input bit term);
        bit is_bcn, fw, good, last;
        is_bcn = 1'b0;
        if (plen >= 3) is_bcn = hdr_ok(pkt[2]);
        fw   = fwd || !is_bcn;
        good = is_bcn && term && (plen == 13);
        for (int i = 0; i < plen; i++) begin
            if (i >= 3) repeat ($urandom_range(0, 2)) idle_step();
            last = term && (i == plen - 1);
            if (fw) begin
                exp_wr[cyc + 3]   = 1'b1;
                exp_data[cyc + 3] = pkt[i];
                exp_vwr[cyc + 3]  = last;
            end
            if (good && last) exp_rv[cyc + 1] = 1'b1;
            in_data_wr = 1'b1; in_data = pkt[i];
            in_data_valid = last; in_data_valid_wr = last;
            step();
        end
        in_data_wr = 1'b0; in_data_valid = 1'b0; in_data_valid_wr = 1'b0;
        if (is_bcn && !good && m_err != 16'hFFFF) m_err = m_err + 16'd1;
        if (good) begin
            m_src    = pkt[2][79:32];
            m_ts     = pkt[5][95:48];
            m_dmac   = pkt[6][127:80];
            m_dir    = pkt[6][79];
            m_tb     = pkt[6][63:32];
            m_esw    = pkt[7][127:0];
            m_node   = pkt[8][127:120];
            m_bufm   = pkt[8][119:112];
            m_eos_md = pkt[9][127:0];
            m_eos_q  = pkt[10][127:104];
            m_goe    = {pkt[11][127:0], pkt[12][127:0]};
            m_rpt_cnt = m_rpt_cnt + 32'd1;
        end
    endtask

    task automatic check_report();
        chk("rpt_cnt", rpt_cnt, m_rpt_cnt);
        chk("err_cnt", err_cnt, m_err);
        chk("rpt_src_mac", rpt_src_mac, m_src);
        chk("rpt_timestamp", rpt_timestamp, m_ts);
        chk("rpt_direct_mac", rpt_direct_mac, m_dmac);
        chk("rpt_direction", rpt_direction, m_dir);
        chk("rpt_token_bucket", rpt_token_bucket, m_tb);
        chk("rpt_esw_cnt", rpt_esw_cnt, m_esw);
        chk("rpt_node_id", rpt_node_id, m_node);
        chk("rpt_bufm_id_cnt", rpt_bufm_id_cnt, m_bufm);
        chk("rpt_eos_md_cnt", rpt_eos_md_cnt, m_eos_md);
        chk("rpt_eos_q_used", rpt_eos_q_used, m_eos_q);
        chk("rpt_goe_cnt", rpt_goe_cnt, m_goe);
    endtask

    task automatic settle(input int n);
        repeat (n) idle_step();
        check_report();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_data_wr = 1'b0; in_data_valid = 1'b0; in_data_valid_wr = 1'b0;
        for (int c = cyc + 1; c < cyc + 8; c++) begin
            exp_wr[c] = 1'b0; exp_vwr[c] = 1'b0; exp_rv[c] = 1'b0;
        end
        model_clear();
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
`ifdef BREPORT_FWD_EN
        fwd = 1'b1;
`else
        fwd = 1'b0;
`endif
        for (int c = 0; c < MAXC; c++) begin
            exp_wr[c] = 1'b0; exp_data[c] = '0; exp_vwr[c] = 1'b0; exp_rv[c] = 1'b0;
        end
        model_clear();
        rst = 1'b1;
        in_data_wr = 1'b0; in_data = '0; in_data_valid = 1'b0; in_data_valid_wr = 1'b0;
        step();
        step();
        check_report();
        rst = 1'b0;
        idle_step();

        // Full beacon with known timestamp, direction and token bucket
        mk_pkt(13, 1'b1, 1'b1);
        pkt[5][95:48] = 48'h123456789ABC;
        pkt[6][79]    = 1'b1;
        pkt[6][63:32] = 32'hDEADBEEF;
        send_pkt(1'b1);
        settle(5);
        chk("beacon_ts", rpt_timestamp, 48'h123456789ABC);
        chk("beacon_dir", rpt_direction, 1'b1);
        chk("beacon_tb", rpt_token_bucket, 32'hDEADBEEF);
        chk("beacon_cnt", rpt_cnt, 32'd1);

        // Ordinary 5-word IPv4 packet
        mk_pkt(5, 1'b0, 1'b1);
        send_pkt(1'b1);
        settle(5);

        // Beacon truncated at index 8
        mk_pkt(9, 1'b1, 1'b1);
        send_pkt(1'b1);
        settle(5);
        chk("trunc_err", err_cnt, 16'd2 - 16'd1);

        // Beacon aborted at index 6, then a 2-word packet
        mk_pkt(6, 1'b1, 1'b0);
        send_pkt(1'b0);
        mk_pkt(2, 1'b0, 1'b1);
        send_pkt(1'b1);
        settle(5);

        // Reset while a beacon is at index 9, then a full beacon
        mk_pkt(9, 1'b1, 1'b0);
        send_pkt(1'b0);
        do_reset();
        settle(2);
        mk_pkt(13, 1'b1, 1'b1);
        send_pkt(1'b1);
        settle(5);
        chk("post_rst_cnt", rpt_cnt, 32'd1);
        chk("post_rst_err", err_cnt, 16'd0);

        // Random mix of good, short, truncated, aborted and overlong packets
        for (int p = 0; p < 40; p++) begin
            case ($urandom_range(0, 6))
                0, 1: begin mk_pkt(13, 1'b1, 1'b1); send_pkt(1'b1); settle($urandom_range(2, 4)); end
                2: begin mk_pkt($urandom_range(2, 8), 1'b0, 1'b1); send_pkt(1'b1); settle($urandom_range(2, 4)); end
                3: begin mk_pkt($urandom_range(3, 12), 1'b1, 1'b1); send_pkt(1'b1); settle($urandom_range(2, 4)); end
                4: begin mk_pkt($urandom_range(3, 12), 1'b1, 1'b0); send_pkt(1'b0); end
                5: begin mk_pkt($urandom_range(2, 6), 1'b0, 1'b0); send_pkt(1'b0); end
                default: begin mk_pkt($urandom_range(14, 16), 1'b1, 1'b1); send_pkt(1'b1); settle($urandom_range(2, 4)); end
            endcase
        end
        mk_pkt(4, 1'b0, 1'b1);
        send_pkt(1'b1);
        settle(6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/breport_parse.md
BREPORT_PARSE -- requirements
Module: breport_parse

Interface
REQ-001 SHALL have these parameters: CNC_MAC, default 48'h010203040506, the destination MAC that a beacon report must carry; RPT_WORDS, default 13, the beacon report length in 134-bit words.
REQ-002 SHALL have one clock and one reset: `clk`, in, 1, the single clock; `rst`, in, 1, asynchronous active-high reset.
REQ-003 SHALL have these stream inputs: `in_data_wr` in 1; `in_data` in 134; `in_data_valid` in 1; `in_data_valid_wr` in 1. The word tag is [133:132]: 01 = first word, 11 = middle word, 10 = last word.
REQ-004 SHALL have these stream outputs, which carry the non-beacon traffic: `out_data_wr` out 1; `out_data` out 134; `out_data_valid` out 1; `out_data_valid_wr` out 1.
REQ-005 SHALL have these report outputs:
- `rpt_valid` out 1: one-cycle pulse per accepted report.
- `rpt_src_mac` out 48.
- `rpt_timestamp` out 48.
- `rpt_direct_mac` out 48.
- `rpt_direction` out 1.
- `rpt_token_bucket` out 32.
- `rpt_esw_cnt` out 128: {pktin, pktout}.
- `rpt_node_id` out 8.
- `rpt_bufm_id_cnt` out 8.
- `rpt_eos_md_cnt` out 128: {mdin, mdout}.
- `rpt_eos_q_used` out 24: {q0, q1, q2, q3}.
- `rpt_goe_cnt` out 256: {pktin, port0out, port1out, discard}.
- `rpt_cnt` out 32: accepted-report counter.
- `err_cnt` out 16: malformed-report counter.

Function
REQ-006 SHALL count words per packet with a 4-bit index; the index is 0 on a word tagged 01 and increments on each `in_data_wr`.
REQ-007 SHALL classify a packet as a beacon report at index 2 when all of the following hold: [127:80]==CNC_MAC, [31:16]==16'h88F7, [11:8]==4'hE.
REQ-008 SHALL delay the stream through a 3-stage register pipeline, so output latency is exactly 3 cycles for forwarded words.
REQ-009 SHALL forward a non-beacon packet word-for-word unchanged, including packets shorter than 3 words (these are classified non-beacon when the 10 tag arrives).
REQ-010 SHALL suppress a beacon packet completely: `out_data_wr` stays 0 for all of its words.
REQ-011 SHALL use the states IDLE, CLASS (index 1–2), BEACON, PASS and DISCARD:
- IDLE: on tag 01 go to CLASS.
- CLASS: at index 2 go to BEACON or PASS.
- PASS: on tag 10 go to IDLE.
- BEACON: on tag 10 at index 12 go to IDLE.
- DISCARD: on tag 10 go to IDLE.
REQ-012 SHALL capture fields into shadow registers in BEACON (indexes count 0..12 from the first word):
- idx2: src MAC = [79:32].
- idx5: timestamp = [95:48].
- idx6: direct MAC = [127:80], direction = [79], token bucket = [63:32].
- idx7: ESW counters = [127:0].
- idx8: node id = [127:120], bufm id count = [119:112].
- idx9: EOS metadata counters = [127:0].
- idx10: EOS queue-used values = [127:104].
- idx11: GOE counters [255:128] = [127:0].
- idx12: GOE counters [127:0] = [127:0].
REQ-013 SHALL copy the shadow registers to the `rpt_*` outputs, pulse `rpt_valid`, and increment `rpt_cnt` on the cycle after the word tagged 10 at index 12.
REQ-014 SHALL treat these beacon-packet events as malformed: err_cnt +1, no `rpt_valid`, `rpt_*` outputs held. A tag 10 before index 12 returns to IDLE. A non-10 tag at index 12 moves to DISCARD.
REQ-015 SHALL treat a 01 tag arriving mid-packet in any non-IDLE state as an abort of the current packet. A beacon abort increments err_cnt. A PASS abort is forwarded as-is. The new packet restarts at index 0 in CLASS.
REQ-016 SHALL saturate `err_cnt` at 16'hFFFF and let `rpt_cnt` wrap to 0 after 32'hFFFFFFFF.
REQ-017 SHALL ignore input while `in_data_wr`=0; idle cycles inside a packet do not advance the index.

Reset
REQ-018 SHALL on `rst` assertion, at any time, force all outputs, counters, pipeline stages and shadow registers to 0 and the state to IDLE; a packet in flight is lost without counting an error.

Configuration
REQ-019 SHALL with BREPORT_FWD_EN defined also forward beacon packets downstream unchanged (parsing still occurs); without it, beacon packets are dropped per REQ-010.

Verification
REQ-020 SHALL cover these directed scenarios:
- 13-word beacon, timestamp 48'h123456789ABC, direction 1, token bucket 32'hDEADBEEF -> `rpt_valid` one pulse, fields match, `rpt_cnt`=1, `out_data_wr` never 1.
- 5-word IPv4 packet (ethertype 0800) -> same 5 words out 3 cycles later, `rpt_valid`=0.
- Beacon truncated with tag 10 at index 8 -> `err_cnt`=1, `rpt_*` unchanged, no output words.
- Beacon, then 01 at index 6, then valid 2-word packet -> `err_cnt`=1, the 2-word packet is forwarded.
- `rst` pulse at beacon index 9, then full beacon -> `rpt_cnt`=1, `err_cnt`=0.
- BREPORT_FWD_EN defined, one beacon -> 13 words out and `rpt_valid` pulse.
